// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single line-wide Data_Memory port.
// One transaction in flight at a time; every command and response is registered.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 256,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m1_enable_i,
  input  logic              m0_write_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m0_ack_o,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m0_data_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy_o,
  output logic              owner_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t            r_state;
  logic              r_last;
  logic              r_blk;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_line;

  logic w_el0;
  logic w_el1;
  logic w_any;
  logic w_gnt;

  // The requester just acked sits out one IDLE cycle so it can drop enable.
  assign w_el0 = m0_enable_i & ~(r_blk & ~owner_o);
  assign w_el1 = m1_enable_i & ~(r_blk & owner_o);
  assign w_any = w_el0 | w_el1;
  assign w_gnt = (w_el0 & w_el1) ? ~r_last : w_el1;

  assign m0_data_o = r_line;
  assign m1_data_o = r_line;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= IDLE;
      r_last       <= 1'b1;
      r_blk        <= 1'b0;
      r_cnt        <= '0;
      r_line       <= '0;
      m0_ack_o     <= 1'b0;
      m1_ack_o     <= 1'b0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      busy_o       <= 1'b0;
      owner_o      <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_blk <= 1'b0;
          if (w_any) begin
            r_state      <= BUSY;
            r_cnt        <= '0;
            owner_o      <= w_gnt;
            busy_o       <= 1'b1;
            mem_enable_o <= 1'b1;
            mem_write_o  <= w_gnt ? m1_write_i : m0_write_i;
            mem_addr_o   <= w_gnt ? m1_addr_i : m0_addr_i;
            mem_data_o   <= w_gnt ? m1_data_i : m0_data_i;
          end
        end
        BUSY: begin
          if (mem_ack_i || r_cnt == CNT_LAST) begin
            if (mem_ack_i) begin
              if (!mem_write_o) r_line <= mem_data_i;
            end else begin
              timeout_o <= 1'b1;
              r_line    <= '0;
            end
            r_state      <= DONE;
            mem_enable_o <= 1'b0;
            m0_ack_o     <= ~owner_o;
            m1_ack_o     <= owner_o;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state  <= IDLE;
          m0_ack_o <= 1'b0;
          m1_ack_o <= 1'b0;
          busy_o   <= 1'b0;
          r_last   <= owner_o;
          r_blk    <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, round-robin order,
// command stability, timeout, mid-transaction reset and stray acks.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          m0_enable_i, m1_enable_i;
  logic          m0_write_i, m1_write_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [DW-1:0] m0_data_i, m1_data_i;
  logic          m0_ack_o, m1_ack_o;
  logic [DW-1:0] m0_data_o, m1_data_o;
  logic          mem_enable_o, mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_data_i;
  logic          busy_o, owner_o, timeout_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYC(64)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .m0_enable_i(m0_enable_i),
    .m1_enable_i(m1_enable_i),
    .m0_write_i(m0_write_i),
    .m1_write_i(m1_write_i),
    .m0_addr_i(m0_addr_i),
    .m1_addr_i(m1_addr_i),
    .m0_data_i(m0_data_i),
    .m1_data_i(m1_data_i),
    .m0_ack_o(m0_ack_o),
    .m1_ack_o(m1_ack_o),
    .m0_data_o(m0_data_o),
    .m1_data_o(m1_data_o),
    .mem_enable_o(mem_enable_o),
    .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i),
    .busy_o(busy_o),
    .owner_o(owner_o),
    .timeout_o(timeout_o)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b0;
    m0_enable_i = 0; m1_enable_i = 0;
    m0_write_i = 0; m1_write_i = 0;
    m0_addr_i = '0; m1_addr_i = '0;
    m0_data_i = '0; m1_data_i = '0;
    mem_ack_i = 0; mem_data_i = '0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_men", mem_enable_o, 0);
    chk("rst_to", timeout_o, 0);
    chk("rst_own", owner_o, 0);
    chk("rst_line", m0_data_o, 0);
    chk("rst_ack", {m0_ack_o, m1_ack_o}, 0);
    step();
    rst_i = 1'b1;
    step();

    // m0 read, memory answers after 10 cycles with line 0x5
    m0_enable_i = 1; m0_addr_i = 32'h0;
    step();
    chk("rd_men", mem_enable_o, 1);
    chk("rd_own", owner_o, 0);
    chk("rd_busy", busy_o, 1);
    chk("rd_wr", mem_write_o, 0);
    repeat (9) begin
      step();
      chk("rd_wait_ack", {m0_ack_o, m1_ack_o}, 0);
    end
    mem_ack_i = 1; mem_data_i = 256'h5;
    step();
    chk("rd_ack0", m0_ack_o, 1);
    chk("rd_ack1", m1_ack_o, 0);
    chk("rd_data", m0_data_o, 256'h5);
    chk("rd_men_off", mem_enable_o, 0);
    chk("rd_busy_done", busy_o, 1);
    mem_ack_i = 0; m0_enable_i = 0;
    step();
    chk("rd_pulse", m0_ack_o, 0);
    chk("rd_idle", busy_o, 0);

    // both requesting from reset: strict m0,m1,m0,m1
    rst_i = 0;
    step();
    rst_i = 1;
    m0_enable_i = 1; m1_enable_i = 1;
    m0_addr_i = 32'h10; m1_addr_i = 32'h20;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_own", owner_o, k[0]);
      chk("rr_addr", mem_addr_o, k[0] ? 256'h20 : 256'h10);
      mem_ack_i = 1; mem_data_i = DW'(k + 1);
      step();
      chk("rr_ack0", m0_ack_o, !k[0]);
      chk("rr_ack1", m1_ack_o, k[0]);
      chk("rr_line", m1_data_o, DW'(k + 1));
      mem_ack_i = 0;
      step();
      chk("rr_idle", busy_o, 0);
    end
    m0_enable_i = 0; m1_enable_i = 0;
    step();

    // m1 write, m0 and m1 inputs wiggle during BUSY
    m1_enable_i = 1; m1_write_i = 1;
    m1_addr_i = 32'h400; m1_data_i = 256'hA5;
    step();
    chk("wr_own", owner_o, 1);
    chk("wr_wr", mem_write_o, 1);
    for (int k = 0; k < 5; k++) begin
      m0_addr_i = $urandom;
      m1_addr_i = $urandom;
      m1_data_i = DW'($urandom);
      m1_write_i = k[0];
      step();
      chk("wr_addr", mem_addr_o, 256'h400);
      chk("wr_data", mem_data_o, 256'hA5);
      chk("wr_men", mem_enable_o, 1);
    end
    mem_ack_i = 1; mem_data_i = 256'hDEAD;
    step();
    chk("wr_ack1", m1_ack_o, 1);
    chk("wr_ack0", m0_ack_o, 0);
    chk("wr_line", m1_data_o, 256'h4);
    mem_ack_i = 0; m1_enable_i = 0; m1_write_i = 0;
    step();
    step();

    // stray mem_ack in IDLE
    mem_ack_i = 1; mem_data_i = 256'hBAD;
    step();
    chk("sp_busy", busy_o, 0);
    chk("sp_ack", {m0_ack_o, m1_ack_o}, 0);
    chk("sp_men", mem_enable_o, 0);
    chk("sp_line", m0_data_o, 256'h4);
    mem_ack_i = 0;
    step();
    chk("sp_busy2", busy_o, 0);

    // memory never answers: timeout after 64 BUSY cycles
    m0_enable_i = 1; m0_write_i = 0; m0_addr_i = 32'h80;
    step();
    chk("to_men", mem_enable_o, 1);
    repeat (63) step();
    chk("to_pre", timeout_o, 0);
    chk("to_pre_men", mem_enable_o, 1);
    step();
    chk("to_set", timeout_o, 1);
    chk("to_ack", m0_ack_o, 1);
    chk("to_line", m0_data_o, 0);
    chk("to_men_off", mem_enable_o, 0);
    m0_enable_i = 0;
    step();
    step();
    m1_enable_i = 1; m1_addr_i = 32'h44;
    step();
    chk("to2_own", owner_o, 1);
    mem_ack_i = 1; mem_data_i = 256'h77;
    step();
    chk("to2_ack", m1_ack_o, 1);
    chk("to2_line", m1_data_o, 256'h77);
    chk("to2_sticky", timeout_o, 1);
    mem_ack_i = 0; m1_enable_i = 0;
    step();
    step();

    // reset in the middle of BUSY
    m0_enable_i = 1; m0_addr_i = 32'h123;
    step();
    chk("mr_busy", busy_o, 1);
    step();
    rst_i = 0;
    #1;
    chk("mr_busy0", busy_o, 0);
    chk("mr_men0", mem_enable_o, 0);
    chk("mr_addr0", mem_addr_o, 0);
    chk("mr_to0", timeout_o, 0);
    chk("mr_line0", m0_data_o, 0);
    chk("mr_ack0", {m0_ack_o, m1_ack_o}, 0);
    step();
    chk("mr_noack", {m0_ack_o, m1_ack_o}, 0);
    rst_i = 1;
    step();
    chk("mr_own", owner_o, 0);
    chk("mr_men", mem_enable_o, 1);
    chk("mr_addr", mem_addr_o, 256'h123);
    mem_ack_i = 1; mem_data_i = 256'h99;
    step();
    chk("mr_ack", m0_ack_o, 1);
    chk("mr_line", m0_data_o, 256'h99);
    mem_ack_i = 0; m0_enable_i = 0;
    step();
    chk("mr_end", m0_ack_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
